// File: rtl/mef_pattern_det.sv
// Serial pattern detector: Y tracks the matched prefix length of a loadable PAT_W-bit pattern.
// Optional saturating match counter is built when MEF_MATCH_CNT_EN is defined.
module mef_pattern_det #(
  parameter int unsigned      PAT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = 8'b1011_0110,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                       CLK,
  input  logic                       CLR_N,
  input  logic                       EN,
  input  logic                       E,
  input  logic                       PAT_LOAD,
  input  logic [PAT_W-1:0]           PAT_IN,
  output logic [$clog2(PAT_W+1)-1:0] Y,
  output logic                       MATCH,
  output logic [CNT_W-1:0]           MATCH_CNT
);

  localparam int unsigned YW = $clog2(PAT_W + 1);
  localparam int          PW = int'(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_nx;
  logic [PAT_W-1:0] hist_q, hist_nx;
  logic [YW-1:0]    k_q, k_nx;
  logic             match_q, match_nx;

  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] pref;
  logic [YW-1:0]    k_acc;
  int               lim;

  // State register
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      k_q     <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_nx;
      hist_q  <= hist_nx;
      k_q     <= k_nx;
      match_q <= match_nx;
    end
  end

  // Next state: longest pattern prefix that is a suffix of the history plus the new bit.
  // A new match can be at most one bit longer than the current one, so only j <= k+1 is tried.
  always_comb begin
    pat_nx   = pat_q;
    hist_nx  = hist_q;
    k_nx     = k_q;
    match_nx = 1'b0;
    cand     = {hist_q[PAT_W-2:0], E};
    mask     = '0;
    pref     = '0;
    k_acc    = '0;
    lim      = (!OVERLAP && (k_q == YW'(PAT_W))) ? 1 : int'(k_q) + 1;

    for (int j = 1; j <= PW; j++) begin
      mask = {PAT_W{1'b1}} >> (PW - j);
      pref = pat_q >> (PW - j);
      if ((j <= lim) && (((cand ^ pref) & mask) == '0)) k_acc = YW'(j);
    end

    if (PAT_LOAD) begin
      pat_nx  = PAT_IN;
      hist_nx = '0;
      k_nx    = '0;
    end else if (EN) begin
      hist_nx  = cand;
      k_nx     = k_acc;
      match_nx = (k_acc == YW'(PAT_W));
    end
  end

  assign Y     = k_q;
  assign MATCH = match_q;

`ifdef MEF_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating match counter, cleared by a pattern load
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt_q <= '0;
    end else if (PAT_LOAD) begin
      cnt_q <= '0;
    end else if (match_nx && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign MATCH_CNT = cnt_q;
`else
  assign MATCH_CNT = '0;
`endif

endmodule

// File: tb/tb_mef_pattern_det.sv
// Bench for mef_pattern_det: three instances (overlap, non-overlap, 2-bit counter) share one
// stimulus stream and are checked against a history-based reference model.
module tb_mef_pattern_det;

  logic       CLK = 1'b0;
  logic       CLR_N;
  logic       EN, E, PAT_LOAD;
  logic [3:0] PAT_IN;

  logic [2:0] y_a, y_b, y_c;
  logic       m_a, m_b, m_c;
  logic [7:0] c_a, c_b;
  logic [1:0] c_c;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [3:0] RST_PAT = 4'b1001;

  int         ov[3]   = '{1, 0, 1};
  int         cmax[3] = '{255, 255, 3};
  int         mk[3];
  bit         mm[3];
  int         mc[3];
  logic [31:0] mh[3];
  int         ml[3];
  logic [3:0] mpat;

  mef_pattern_det #(.PAT_W(4), .PAT_RST(RST_PAT), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .E(E), .PAT_LOAD(PAT_LOAD), .PAT_IN(PAT_IN),
    .Y(y_a), .MATCH(m_a), .MATCH_CNT(c_a));
  mef_pattern_det #(.PAT_W(4), .PAT_RST(RST_PAT), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .E(E), .PAT_LOAD(PAT_LOAD), .PAT_IN(PAT_IN),
    .Y(y_b), .MATCH(m_b), .MATCH_CNT(c_b));
  mef_pattern_det #(.PAT_W(4), .PAT_RST(RST_PAT), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .E(E), .PAT_LOAD(PAT_LOAD), .PAT_IN(PAT_IN),
    .Y(y_c), .MATCH(m_c), .MATCH_CNT(c_c));

  always #5 CLK = ~CLK;

  // Longest j such that the newest j history bits equal the top j pattern bits
  function automatic int best(logic [31:0] h, int hl, logic [3:0] p);
    int b = 0;
    int lim = (hl < 4) ? hl : 4;
    for (int j = 1; j <= lim; j++) begin
      bit ok = 1'b1;
      for (int i = 0; i < j; i++) if (h[i] != p[4-j+i]) ok = 1'b0;
      if (ok) b = j;
    end
    return b;
  endfunction

  task automatic model_reset();
    mpat = RST_PAT;
    for (int d = 0; d < 3; d++) begin
      mk[d] = 0; mm[d] = 1'b0; mc[d] = 0; mh[d] = '0; ml[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      mm[d] = 1'b0;
      if (PAT_LOAD) begin
        mk[d] = 0; ml[d] = 0; mh[d] = '0; mc[d] = 0;
      end else if (EN) begin
        if (ov[d] == 0 && mk[d] == 4) begin
          ml[d] = 0; mh[d] = '0;
        end
        mh[d] = {mh[d][30:0], E};
        if (ml[d] < 31) ml[d]++;
        mk[d] = best(mh[d], ml[d], mpat);
        if (mk[d] == 4) begin
          mm[d] = 1'b1;
          if (mc[d] < cmax[d]) mc[d]++;
        end
      end
    end
    if (PAT_LOAD) mpat = PAT_IN;
  endtask

  task automatic chk_one(string tag, int yv, logic mv, int cv, int d);
    int ec;
`ifdef MEF_MATCH_CNT_EN
    ec = mc[d];
`else
    ec = 0;
`endif
    vectors += 3;
    assert (yv === mk[d]) else begin
      miscompares++;
      $error("FAIL %s.Y observed=%0d expected=%0d", tag, yv, mk[d]);
    end
    assert (mv === mm[d]) else begin
      miscompares++;
      $error("FAIL %s.MATCH observed=%0b expected=%0b", tag, mv, mm[d]);
    end
    assert (cv === ec) else begin
      miscompares++;
      $error("FAIL %s.MATCH_CNT observed=%0d expected=%0d", tag, cv, ec);
    end
  endtask

  task automatic chk_all();
    chk_one("ovl", int'(y_a), m_a, int'(c_a), 0);
    chk_one("novl", int'(y_b), m_b, int'(c_b), 1);
    chk_one("cnt2", int'(y_c), m_c, int'(c_c), 2);
  endtask

  task automatic step(logic en, logic e, logic ld, logic [3:0] pin);
    @(negedge CLK);
    EN = en; E = e; PAT_LOAD = ld; PAT_IN = pin;
    @(posedge CLK);
    model_edge();
    #1;
    chk_all();
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    CLR_N = 1'b0;
    #1;
    model_reset();
    chk_all();
    #1 CLR_N = 1'b1;
  endtask

  initial begin
    logic [6:0] s1;
    int ya_exp[7] = '{1, 2, 3, 4, 2, 3, 4};
    int yb_exp[7] = '{1, 2, 3, 4, 0, 1, 1};
    CLR_N = 1'b0; EN = 1'b0; E = 1'b0; PAT_LOAD = 1'b0; PAT_IN = '0;
    #2;
    model_reset();
    chk_all();
    #10 CLR_N = 1'b1;

    // Basic stream 1011011 in both overlap modes
    step(1'b0, 1'b0, 1'b1, 4'b1011);
    s1 = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s1[6-i], 1'b0, 4'b0);
      vectors += 2;
      assert (int'(y_a) === ya_exp[i]) else begin
        miscompares++;
        $error("FAIL s1_ovl_y[%0d] observed=%0d expected=%0d", i, y_a, ya_exp[i]);
      end
      assert (int'(y_b) === yb_exp[i]) else begin
        miscompares++;
        $error("FAIL s1_novl_y[%0d] observed=%0d expected=%0d", i, y_b, yb_exp[i]);
      end
    end

    // Gaps between bits, then idle cycles holding Y at 4
    step(1'b0, 1'b0, 1'b1, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s1[6-i], 1'b0, 4'b0);
      step(1'b0, 1'b1, 1'b0, 4'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'b0);

    // Load collides with a completing bit
    step(1'b0, 1'b0, 1'b1, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 4'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0);
    step(1'b1, 1'b1, 1'b1, 4'b0110);
    step(1'b1, 1'b0, 1'b0, 4'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0);

    // Reset mid-stream
    step(1'b0, 1'b0, 1'b1, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 4'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0);
    reset_pulse();
    step(1'b1, 1'b1, 1'b0, 4'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0);

    // Counter saturation with an all-ones pattern
    step(1'b0, 1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 4'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic en, e, ld;
      logic [3:0] pin;
      en  = ($urandom_range(0, 9) < 7);
      e   = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 29) == 0);
      pin = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) reset_pulse();
      step(en, e, ld, pin);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mef_pattern_det.md
# mef_pattern_det

Parametrised serial pattern-detector state machine: the next generation of the team's 8-bit-output Moore FSM. It is generalised to a runtime-loadable pattern of PAT_W bits, with selectable overlap mode, a one-cycle match pulse and an optional saturating match counter. It sits on a serial bit stream qualified by EN. Y reports the current state index, which is the number of pattern bits currently matched.

## Interface
Parameters:
- PAT_W, 8, pattern length in bits; legal range 2..16.
- PAT_RST, 8'b1011_0110, pattern value loaded at reset; PAT_W bits wide.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- CNT_W, 8, width of the match counter.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- CLR_N  in  1  reset; asynchronous assert, active-low.
- EN  in  1  serial bit valid; E is sampled only when EN=1.
- E  in  1  serial data bit.
- PAT_LOAD  in  1  load strobe for the pattern.
- PAT_IN  in  PAT_W  new pattern value.
- Y  out  $clog2(PAT_W+1)  current state index, 0..PAT_W.
- MATCH  out  1  one-cycle pulse on pattern completion.
- MATCH_CNT  out  CNT_W  saturating count of matches.

## Operation
- Bit order: the first bit received is compared with PAT[PAT_W-1]; the last bit with PAT[0].
- The state is the matched length k, 0..PAT_W. Y = k, registered (Moore).
- Accepted bit (EN=1, PAT_LOAD=0): the next k is the largest j ≤ PAT_W such that the last j bits of the accepted history (including the new bit) equal PAT[PAT_W-1 -: j]. If no such j exists, k = 0.
- OVERLAP=1: history after a match keeps all bits, so k can move from PAT_W to a proper prefix-suffix length.
- OVERLAP=0: from k=PAT_W, history restarts empty before the new bit is evaluated. The next k is therefore 1 or 0 only.
- MATCH is registered. It is 1 in exactly the cycle in which Y first becomes PAT_W due to an accepted bit, and 0 otherwise. If Y holds PAT_W while EN=0, MATCH does not repeat.
- MATCH_CNT increments with each MATCH and saturates at 2^CNT_W-1, with no wrap.
- PAT_LOAD=1 has these effects on the next edge:
  - the pattern register takes PAT_IN;
  - k is set to 0 and history is cleared;
  - MATCH is set to 0;
  - MATCH_CNT is set to 0.
- PAT_LOAD and EN both high: the load wins and the bit is discarded.
- EN=0 with PAT_LOAD=0: all state holds and MATCH is set to 0.

## Timing
- Reset values (immediate on CLR_N low, independent of CLK):
  - Y=0, MATCH=0, MATCH_CNT=0;
  - pattern register = PAT_RST;
  - history cleared.
- Reset release is synchronous to the first CLK edge with CLR_N=1. That first edge may already accept a bit.
- Latency: a bit sampled at edge n is reflected in Y and MATCH after edge n, visible in cycle n+1.
- Back-to-back accepted bits every cycle are supported. The minimum match spacing is 1 cycle in OVERLAP=1 with a self-overlapping pattern (e.g. all-ones).
- Reset mid-stream abandons the partial match. MATCH_CNT is lost.
- A PAT_LOAD in the same cycle that would complete a match suppresses that match.

## Configuration
- MEF_MATCH_CNT_EN defined: the CNT_W-bit saturating counter is built and MATCH_CNT behaves as in Operation.
- Undefined: no counter flops are generated and MATCH_CNT is tied to 0. Y and MATCH are unchanged.

## Test plan
All scenarios use PAT_W=4 and pattern 1011 loaded via PAT_LOAD, except where stated.
- OVERLAP=1, EN=1, E = 1,0,1,1,0,1,1 -> Y = 1,2,3,4,2,3,4; MATCH high after bits 4 and 7; MATCH_CNT=2.
- OVERLAP=0, same stream -> Y = 1,2,3,4,0,1,1; MATCH once; MATCH_CNT=1.
- Gaps: EN=0 interleaved between every bit of 1,0,1,1 -> Y holds during gaps and reaches 4; MATCH is a single pulse while Y stays 4 through the following idle cycles.
- Load collision: after 1,0,1, assert PAT_LOAD with PAT_IN=0110 and EN=1, E=1 -> no MATCH; Y=0; MATCH_CNT=0. Then 0,1,1,0 -> MATCH; Y=4.
- Reset mid-stream: after 1,0,1, pulse CLR_N low between edges -> Y=0 and MATCH_CNT=0 immediately; pattern reverts to PAT_RST; the next bit 1 gives Y=1.
- Saturation, with MEF_MATCH_CNT_EN defined, CNT_W=2, OVERLAP=1, pattern 1111, eight 1s -> MATCH_CNT = 0,0,0,1,2,3,3,3. With the macro undefined -> MATCH_CNT stays 0 and MATCH pulses are unchanged.
